// File: rtl/mstream_matrix_arb_pkg.sv
// mstream_matrix_arb_pkg: shared types and constants for the matrix stream arbiter.
// Contents: state_t (IDLE/BURST), MSTREAM_ROWS, MAX_REQ, clog2_min1().
package mstream_matrix_arb_pkg;
    typedef enum logic {IDLE, BURST} state_t;
    localparam int MSTREAM_ROWS = 3;
    localparam int MAX_REQ = 8;
    // Counter width that never collapses to zero bits for a 1-beat matrix.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mstream_rr_picker.sv
// mstream_rr_picker: combinational round-robin pick starting after last_grant.
// Ports: req (request vector), last_grant (previous winner),
//        grant (first set request above last_grant, wrapping), any_req.
module mstream_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IW = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      grant,
    output logic               any_req
);
    logic [IW-1:0] idx;
    // Walk the rotation from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant = last_grant;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_grant) + k) % NUM_REQ);
            if (req[idx]) grant = idx;
        end
    end
    assign any_req = |req;
endmodule

// File: rtl/mstream_matrix_arb.sv
// mstream_matrix_arb: round-robin arbiter of NUM_REQ matrix streams onto one sink,
// locking the grant for BEATS_PER_MATRIX beats, with one registered output stage.
// Ports: sys_clk, reset (sync, active-high); req_vld/req_rdy/req_r0..r2 (packed
//        per-requester inputs); out_vld/out_rdy/out_r0..r2/out_last/out_src (sink side).
module mstream_matrix_arb
    import mstream_matrix_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_WIDTH = 32,
    parameter int BEATS_PER_MATRIX = 3
) (
    input  logic                          sys_clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_vld,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_r0,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_r1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_r2,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [DATA_WIDTH-1:0]         out_r0,
    output logic [DATA_WIDTH-1:0]         out_r1,
    output logic [DATA_WIDTH-1:0]         out_r2,
    output logic                          out_last,
    output logic [$clog2(NUM_REQ)-1:0]    out_src
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = clog2_min1(BEATS_PER_MATRIX);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_MATRIX - 1);

    state_t        state;
    logic [IW-1:0] grant;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] pick;
    logic [BW-1:0] beat_cnt;
    logic          any_req;
    logic          can_load;
    logic          in_xfer;
    logic          last_beat;

    mstream_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
        .req        (req_vld),
        .last_grant (last_grant),
        .grant      (pick),
        .any_req    (any_req)
    );

    // The output register can take a new beat when empty or draining this cycle.
    assign can_load  = !out_vld || out_rdy;
    assign in_xfer   = (state == BURST) && req_vld[grant] && can_load;
    assign last_beat = beat_cnt == LAST_BEAT;

    always_comb begin
        req_rdy = '0;
        if (state == BURST) req_rdy[grant] = can_load;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            beat_cnt   <= '0;
            out_vld    <= 1'b0;
            out_last   <= 1'b0;
            out_src    <= '0;
            out_r0     <= '0;
            out_r1     <= '0;
            out_r2     <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                state <= BURST;
                grant <= pick;
            end
            if (in_xfer) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                if (last_beat) begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                out_vld  <= 1'b1;
                out_src  <= grant;
                out_last <= last_beat;
                out_r0   <= req_r0[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                out_r1   <= req_r1[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                out_r2   <= req_r2[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mstream_matrix_arb.sv
// tb_mstream_matrix_arb: randomized scoreboard bench for mstream_matrix_arb, plus a
// 4-requester single-beat instance for rotation with out_last on every beat.
module tb_mstream_matrix_arb;
    localparam int N = 2;
    localparam int DW = 32;
    localparam int B = 3;
    localparam int IW = 1;
    localparam int N2 = 4;
    localparam int DW2 = 8;

    typedef struct {
        logic [IW-1:0] src;
        logic          last;
        logic [DW-1:0] r0, r1, r2;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req_vld, req_rdy;
    logic [N*DW-1:0] req_r0, req_r1, req_r2;
    logic out_vld, out_rdy, out_last;
    logic [DW-1:0] out_r0, out_r1, out_r2;
    logic [IW-1:0] out_src;

    logic [N2-1:0] b_req_vld, b_req_rdy;
    logic [N2*DW2-1:0] b_req_r0, b_req_r1, b_req_r2;
    logic b_out_vld, b_out_last;
    logic [DW2-1:0] b_out_r0, b_out_r1, b_out_r2;
    logic [1:0] b_out_src;

    int checks = 0;
    int failures = 0;

    beat_t q[$];
    bit m_free = 1'b1;
    int m_last = N - 1;
    int m_grant = 0;
    int m_cnt = 0;
    bit occ = 1'b0;

    always #5 clk = ~clk;

    mstream_matrix_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .BEATS_PER_MATRIX(B)) dut (
        .sys_clk(clk), .reset(reset), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_r0(req_r0), .req_r1(req_r1), .req_r2(req_r2),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_r0(out_r0), .out_r1(out_r1),
        .out_r2(out_r2), .out_last(out_last), .out_src(out_src)
    );

    mstream_matrix_arb #(.NUM_REQ(N2), .DATA_WIDTH(DW2), .BEATS_PER_MATRIX(1)) dut_b (
        .sys_clk(clk), .reset(reset), .req_vld(b_req_vld), .req_rdy(b_req_rdy),
        .req_r0(b_req_r0), .req_r1(b_req_r1), .req_r2(b_req_r2),
        .out_vld(b_out_vld), .out_rdy(1'b1), .out_r0(b_out_r0), .out_r1(b_out_r1),
        .out_r2(b_out_r2), .out_last(b_out_last), .out_src(b_out_src)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Next owner: first valid requester after the previous owner, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int j = (last + k) % N;
            if (v[IW'(j)]) return j;
        end
        return 0;
    endfunction

    // Input-side model: samples just before each rising edge and records accepted beats.
    always begin
        logic [N-1:0] exp_rdy;
        beat_t bt;
        @(negedge clk);
        #4;
        if (reset) begin
            m_free = 1'b1;
            m_last = N - 1;
            m_cnt = 0;
            q.delete();
        end else if (m_free) begin
            chk("req_rdy_idle", req_rdy, 0);
            if (req_vld != 0) begin
                m_grant = rr_pick(req_vld, m_last);
                m_free = 1'b0;
                m_cnt = 0;
            end
        end else begin
            exp_rdy = '0;
            if (!occ || out_rdy) exp_rdy[IW'(m_grant)] = 1'b1;
            chk("req_rdy", req_rdy, exp_rdy);
            if (req_vld[IW'(m_grant)] && exp_rdy[IW'(m_grant)]) begin
                bt.src = IW'(m_grant);
                bt.last = (m_cnt == B - 1);
                bt.r0 = req_r0[m_grant*DW +: DW];
                bt.r1 = req_r1[m_grant*DW +: DW];
                bt.r2 = req_r2[m_grant*DW +: DW];
                q.push_back(bt);
                m_cnt++;
                if (m_cnt == B) begin
                    m_last = m_grant;
                    m_free = 1'b1;
                    m_cnt = 0;
                end
            end
        end
    end

    // Output-side monitor: compares the presented beat every cycle, pops on transfer.
    always begin
        @(negedge clk);
        #1;
        chk("out_vld", out_vld, q.size() != 0);
        occ = q.size() != 0;
        if (out_vld && q.size() != 0) begin
            chk("out_src", out_src, q[0].src);
            chk("out_last", out_last, q[0].last);
            chk("out_r0", out_r0, q[0].r0);
            chk("out_r1", out_r1, q[0].r1);
            chk("out_r2", out_r2, q[0].r2);
        end
        #3;
        if (!reset && out_vld && out_rdy && q.size() != 0) void'(q.pop_front());
    end

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_r0[i*DW +: DW] = $urandom;
            req_r1[i*DW +: DW] = $urandom;
            req_r2[i*DW +: DW] = $urandom;
        end
    endtask

    task automatic wait_beat2(input int g, input string nm);
        int c = 0;
        while (!(!m_free && m_cnt == 1 && (g < 0 || m_grant == g)) && c < 50) begin
            cycle();
            c++;
        end
        chk(nm, c < 50, 1);
    endtask

    initial begin
        int n;
        int got;
        int exp6[4] = '{1, 3, 1, 3};
        req_vld = '0;
        out_rdy = 1'b0;
        req_r0 = '0;
        req_r1 = '0;
        req_r2 = '0;
        b_req_vld = '0;
        for (int i = 0; i < N2; i++) begin
            b_req_r0[i*DW2 +: DW2] = DW2'(8'h10 + i);
            b_req_r1[i*DW2 +: DW2] = DW2'(8'h20 + i);
            b_req_r2[i*DW2 +: DW2] = DW2'(8'h30 + i);
        end
        repeat (3) cycle();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_out_r0", out_r0, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_b_out_vld", b_out_vld, 0);
        reset = 1'b0;

        // first matrix from requester 0: two cycles to first beat
        req_vld = 2'b01;
        out_rdy = 1'b1;
        n = 0;
        while (n < 8 && !out_vld) begin
            cycle();
            n++;
        end
        chk("first_latency", n, 2);
        repeat (10) cycle();

        // both requesters continuously valid
        req_vld = 2'b11;
        repeat (32) cycle();

        // sink stall mid-matrix
        wait_beat2(-1, "stall_reach");
        out_rdy = 1'b0;
        repeat (5) cycle();
        out_rdy = 1'b1;
        repeat (12) cycle();

        // granted requester 0 drops valid mid-matrix while requester 1 waits
        wait_beat2(0, "lock_reach");
        req_vld = 2'b10;
        repeat (4) begin
            cycle();
            #2 chk("lock_rdy1", req_rdy[1], 0);
        end
        req_vld = 2'b11;
        repeat (12) cycle();

        // random traffic with random sink backpressure
        repeat (400) begin
            cycle();
            req_vld = N'($urandom);
            out_rdy = $urandom_range(3) != 0;
        end

        // reset mid-matrix
        req_vld = 2'b11;
        out_rdy = 1'b1;
        wait_beat2(-1, "reset_reach");
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        chk("mid_rst_out_vld", out_vld, 0);
        chk("mid_rst_req_rdy", req_rdy, 0);
        n = 0;
        while (n < 8 && !out_vld) begin
            cycle();
            n++;
        end
        chk("post_rst_latency", n, 2);
        chk("post_rst_src", out_src, 0);

        // drain
        req_vld = '0;
        repeat (10) cycle();
        chk("drained", q.size(), 0);

        // single-beat matrices, requesters 1 and 3 only
        b_req_vld = 4'b1010;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (b_out_vld) begin
                chk("b_src", b_out_src, exp6[got]);
                chk("b_last", b_out_last, 1);
                chk("b_r0", b_out_r0, 8'h10 + exp6[got]);
                got++;
            end
        end
        chk("b_beats", got, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mstream_matrix_arb.md
Name: mstream_matrix_arb

Overview:
- Arbitrates NUM_REQ Matrix Stream sources onto one Matrix Stream sink, so that several producers can share a single ig/eg path into the DUT.
- Each beat carries three data rows (r0, r1, r2).
- A grant is locked for one whole matrix (BEATS_PER_MATRIX beats). Grants rotate round-robin between matrices.
- A single registered output stage cuts the timing path toward the sink.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..8).
- DATA_WIDTH, 32, width of each data row.
- BEATS_PER_MATRIX, 3, beats per matrix and length of the grant lock (>=1).

Ports:
- sys_clk  in  1  system clock.
- reset  in  1  reset: synchronous, active-high.
- req_vld  in  NUM_REQ  per-requester valid.
- req_rdy  out  NUM_REQ  per-requester ready.
- req_r0  in  NUM_REQ*DATA_WIDTH  row 0, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_r1  in  NUM_REQ*DATA_WIDTH  row 1, same packing.
- req_r2  in  NUM_REQ*DATA_WIDTH  row 2, same packing.
- out_vld  out  1  output valid.
- out_rdy  in  1  sink ready.
- out_r0 / out_r1 / out_r2  out  DATA_WIDTH each  output rows.
- out_last  out  1  final beat of a matrix.
- out_src  out  $clog2(NUM_REQ)  index of the requester that sourced the beat.

Behaviour:
- Transfer rule: a transfer occurs when vld && rdy at the posedge sys_clk, on both the input and output sides.
- Reset (sync, active-high):
  - state=IDLE, beat_cnt=0, last_grant=NUM_REQ-1 (requester 0 wins first).
  - out_vld=0, out_last=0, out_src=0, out_r0/r1/r2=0, req_rdy=0.
  - Reset asserted mid-matrix abandons the matrix: no partial flush, the buffered beat is dropped.
- State IDLE:
  - req_rdy=0.
  - If any req_vld, grant = first set bit searching from last_grant+1 upward with wrap. Grant is registered and state moves to BURST.
  - If no req_vld, stay in IDLE.
- State BURST:
  - req_rdy[grant] = (!out_vld || out_rdy). All other req_rdy bits = 0.
  - Each input transfer loads the output register: rows, out_src=grant, out_last=(beat_cnt==BEATS_PER_MATRIX-1). beat_cnt then increments.
  - On the transfer with beat_cnt==BEATS_PER_MATRIX-1: beat_cnt=0, last_grant=grant, state=IDLE.
- Latency:
  - 2 cycles from req_vld rising in IDLE to out_vld (1 cycle arbitration, 1 cycle register).
  - Steady state inside a matrix: 1 beat per cycle.
  - 1 bubble cycle between consecutive matrices (the IDLE cycle).
- Output register:
  - out_vld sets on an input transfer.
  - out_vld clears on an output transfer with no simultaneous input transfer.
  - Simultaneous output and input transfer: register reloads and out_vld stays 1.
  - While out_vld && !out_rdy, all out_* signals are held stable.
- Lock: the grant is not released while the granted requester deasserts req_vld mid-matrix. The arbiter waits indefinitely; there is no timeout.
- BEATS_PER_MATRIX=1: out_last is always 1 and the grant rotates every beat.
- beat_cnt width: max(1, $clog2(BEATS_PER_MATRIX)).
- Requests arriving during BURST do not preempt the current grant. They are considered only at the next IDLE.
- Fairness: with all NUM_REQ requesters continuously valid, each requester receives exactly one matrix per NUM_REQ matrices.

Decomposition:
- Package mstream_matrix_arb_pkg:
  - state enum {IDLE, BURST}.
  - Constants MSTREAM_ROWS=3 and MAX_REQ=8.
  - Function clog2_min1.
- Sub-module mstream_rr_picker: combinational round-robin pick. Inputs req vector and last_grant; outputs grant index and any_req.

Test Plan:
1. Reset, then req_vld=2'b01 presenting a 3-beat matrix with r0=1/2/3, out_rdy=1 -> out_vld first at cycle 2 after req_vld; beats 1,2,3 on consecutive cycles; out_last only on beat 3; out_src=0.
2. Both requesters continuously valid, 4 matrices -> out_src sequence 0,0,0,1,1,1,0,0,0,1,1,1; one idle cycle between matrices; beats never interleave.
3. out_rdy=0 for 5 cycles mid-matrix at beat 2 -> out_* held stable; req_rdy[grant]=0 while out_vld&&!out_rdy; no beat lost or duplicated after out_rdy returns.
4. Granted requester drops req_vld after beat 1 for 4 cycles while requester 1 is valid -> req_rdy[1] stays 0; beats 2-3 come from requester 0; requester 1 is granted next.
5. reset asserted at beat 2 of a matrix -> next cycle out_vld=0, req_rdy=0; first grant after reset goes to requester 0.
6. NUM_REQ=4, BEATS_PER_MATRIX=1, req_vld=4'b1010 -> out_src alternates 1,3,1,3 with out_last=1 on every beat.
